// File: rtl/npc_ifu.sv
// npc_ifu: single-outstanding instruction fetch FSM; define IFU_MISALIGN_CHECK_EN to trap misaligned next_pc.
module npc_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic [31:0] next_pc,
  input  logic        halt,
  output logic        fault
);
  typedef enum logic [2:0] {
    S_REQ, S_WAIT, S_HOLD, S_HALT
`ifdef IFU_MISALIGN_CHECK_EN
    , S_FAULT
`endif
  } state_t;
  state_t state, state_n;
  logic [31:0] pc;
  always_comb begin
    state_n = state;
    case (state)
      S_REQ:  state_n = req_ready ? S_WAIT : S_REQ;
      S_WAIT: state_n = resp_valid ? S_HOLD : S_WAIT;
      S_HOLD: if (inst_ready) begin
`ifdef IFU_MISALIGN_CHECK_EN
        state_n = halt ? S_HALT : (next_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
        state_n = halt ? S_HALT : S_REQ;
`endif
      end
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      inst    <= 32'h0;
      inst_pc <= 32'h0;
    end else begin
      state <= state_n;
      if (state == S_WAIT && resp_valid) begin
        inst    <= resp_data;
        inst_pc <= pc;
      end
      if (state == S_HOLD && state_n == S_REQ) pc <= next_pc & 32'hFFFF_FFFC;
`ifdef IFU_MISALIGN_CHECK_EN
      if (state == S_HOLD && state_n == S_FAULT) inst_pc <= next_pc;
`endif
    end
  end
  // gated by rst so no request is visible while reset is asserted
  assign req_valid  = rst && state == S_REQ;
  assign req_addr   = pc;
  assign inst_valid = state == S_HOLD;
`ifdef IFU_MISALIGN_CHECK_EN
  assign fault = state == S_FAULT;
`else
  assign fault = 1'b0;
`endif
endmodule

// File: doc/npc_ifu.md
NPC_IFU -- requirements
Module: npc_ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h80000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, output, 1 bit: fetch request to instruction memory.
REQ-005 The block SHALL have port req_ready, input, 1 bit: memory accepts the request.
REQ-006 The block SHALL have port req_addr, output, 32 bits: fetch address, word aligned.
REQ-007 The block SHALL have port resp_valid, input, 1 bit: memory returns instruction data.
REQ-008 The block SHALL have port resp_data, input, 32 bits: the fetched instruction word.
REQ-009 The block SHALL have port inst_valid, output, 1 bit: instruction presented to decode.
REQ-010 The block SHALL have port inst_ready, input, 1 bit: decode/execute consumes the instruction this cycle.
REQ-011 The block SHALL have port inst, output, 32 bits: held instruction word.
REQ-012 The block SHALL have port inst_pc, output, 32 bits: PC of the held instruction.
REQ-013 The block SHALL have port next_pc, input, 32 bits: successor PC from execute, sampled only on consume.
REQ-014 The block SHALL have port halt, input, 1 bit: stop fetching (ebreak retire).
REQ-015 The block SHALL have port fault, output, 1 bit: misaligned next_pc detected.

Function
REQ-016 The state machine SHALL have the states REQ, WAIT, HOLD, HALT and FAULT.
REQ-017 In REQ, the block SHALL drive req_valid=1 and req_addr=pc; on req_ready=1 it SHALL go to WAIT; otherwise it SHALL stay with req_addr stable.
REQ-018 In WAIT, req_valid SHALL be 0; on resp_valid=1 the block SHALL capture resp_data into inst, set inst_pc=pc, and go to HOLD.
REQ-019 resp_valid SHALL be ignored in every state except WAIT.
REQ-020 In HOLD, inst_valid SHALL be 1; inst and inst_pc SHALL be stable until consumed.
REQ-021 In HOLD with inst_ready=1 (consume), pc SHALL load next_pc and the block SHALL go to REQ; inst_valid SHALL fall on the next cycle.
REQ-022 In HOLD with inst_ready=0, the block SHALL stay in HOLD indefinitely.
REQ-023 halt=1 in HOLD together with inst_ready=1 SHALL take priority over the PC update: the block SHALL go to HALT with pc unchanged.
REQ-024 halt=1 in REQ or WAIT SHALL be ignored.
REQ-025 In HALT, req_valid=0 and inst_valid=0; only reset SHALL exit HALT.
REQ-026 Minimum latency, consume to next inst_valid: 3 cycles (1 cycle REQ with req_ready=1, resp_valid in the first WAIT cycle, then HOLD).
REQ-027 At most one request SHALL be outstanding at any time.
REQ-028 pc arithmetic SHALL be 32-bit; the block SHALL NOT compute pc+4 (execute supplies next_pc).

Reset
REQ-029 While rst=0 at a clock edge: state=REQ, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, fault=0.
REQ-030 req_valid SHALL be 0 during reset and 1 in the first cycle after rst returns to 1.
REQ-031 Reset in WAIT SHALL abandon the outstanding request; a late resp_valid SHALL be dropped.

Configuration
REQ-032 With IFU_MISALIGN_CHECK_EN defined, a consume with next_pc[1:0]!=0 SHALL go to FAULT, set fault=1, set inst_pc=next_pc, and stop fetching until reset.
REQ-033 Without IFU_MISALIGN_CHECK_EN, next_pc[1:0] SHALL be forced to 2'b00 on load, fault SHALL be tied 0, and the FAULT state SHALL be absent.
REQ-034 halt SHALL take priority over a misalign fault.

Verification
REQ-035 The bench SHALL check: reset release, req_ready=1, resp_valid next cycle with 32'h00000413 -> req_addr=32'h80000000, then inst_valid=1, inst=32'h00000413, inst_pc=32'h80000000.
REQ-036 The bench SHALL check: req_ready held 0 for 5 cycles -> req_valid=1 and req_addr constant for all 5 cycles; no inst_valid.
REQ-037 The bench SHALL check: inst_ready=0 for 4 cycles in HOLD, then inst_ready=1 with next_pc=32'h80000010 -> inst stable, then next req_addr=32'h80000010.
REQ-038 The bench SHALL check: halt=1 with inst_ready=1 (inst 32'h00100073) -> req_valid stays 0 for at least 10 cycles; inst_valid=0.
REQ-039 The bench SHALL check: rst low in WAIT, then resp_valid arrives after rst release -> response dropped, fresh request to 32'h80000000.
REQ-040 The bench SHALL check: next_pc=32'h80000006 on consume -> with the macro, fault=1 and no further requests; without it, req_addr=32'h80000004.
